systolic_drain: RTL and testbench
=================================

# systolic_drain

- Collects the skewed result stream leaving the bottom edge of the systolic MAC array and re-aligns it into whole rows.
- Buffers aligned rows in a small FIFO and hands them to the downstream consumer over a valid/ready handshake.
- It is the drain-side counterpart of the input skew registers that feed the array: whatever skew is applied on entry, this block removes on exit.
- The array cannot stall, so loss conditions are reported through sticky error flags instead of back-pressure.

## Interface
Parameters:
- WIDTH, 32, bit width of one column result
- COLS, 4, number of array columns (≥2)
- FIFO_DEPTH, 4, aligned rows buffered (power of two, ≥2)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- col_data  input  COLS*WIDTH  column results, column c at bits [c*WIDTH +: WIDTH]
- col_valid  input  COLS  per-column valid; column c of a row arrives c cycles after column 0
- out_data  output  COLS*WIDTH  aligned row, same column packing
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready
- overflow  output  1  sticky: aligned row dropped because FIFO full
- skew_err  output  1  sticky: aligned valid bits disagreed
- err_clear  input  1  synchronous clear of both sticky flags
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- **Deskew:** column c passes through COLS−c registers, covering both data and valid.
  - A row whose column 0 is sampled at edge t is therefore aligned at the deskew outputs after edge t+COLS−1.
- **Alignment check:** each cycle the aligned valid vector is examined.
  - All ones: row_push = 1.
  - All zeros: idle.
  - Any other pattern: skew_err set, no push, partial row discarded.
- **FIFO:** FIFO_DEPTH × COLS*WIDTH, with write pointer, read pointer and count.
  - pop = out_valid & out_ready.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Push while full is accepted only if pop is also asserted that cycle.
  - Push while full without pop: row dropped, overflow set, FIFO contents untouched.
  - Pointers wrap modulo FIFO_DEPTH.
- **out_data:** reads the FIFO head combinationally from the registered storage. It holds stable while out_valid & !out_ready.
- **Sticky flags:** set conditions take priority over err_clear in the same cycle.
- **Reset values:** out_valid=0, level=0, overflow=0, skew_err=0, out_data=0. All deskew valids are 0, and all deskew data registers are 0.
- **Reset mid-operation:** rows in flight in the deskew chain and in the FIFO are discarded. Nothing is emitted until new input arrives.

## Timing
- Column 0 of a row presented in cycle t, with column c presented in cycle t+c:
  - row written into the FIFO at edge t+COLS;
  - out_valid high from cycle t+COLS+1 when the FIFO was empty.
  - Total latency is COLS+1 cycles from the column-0 beat.
- Throughput: one row per cycle sustained while out_ready=1. No bubbles between back-to-back rows.
- level updates on the same edge as the push or pop.
- Flags assert on the edge after the offending aligned cycle, i.e. in the same edge as the would-be push.

## Structure
- No shared package constants are required; all sizing comes from parameters.
- The pointer width ($clog2(FIFO_DEPTH)) is a localparam.
- One sub-module: drain_row_fifo, a synchronous FIFO parameterised by row width and depth.
  - Ports: push, pop, wdata, rdata, empty, full, level.
- The deskew chain is a generate loop in the top module.

## Test plan
- **Single row:** COLS=4; column c = 0x10+c presented in cycles 0..3 → out_valid rises in cycle 5, out_data = {0x13,0x12,0x11,0x10}; with out_ready=1 it drops the next cycle and level returns to 0.
- **Back-to-back stream:** 8 rows in consecutive cycles with out_ready=1 → 8 consecutive out_valid cycles in order, level never exceeds 1, no flags.
- **Overflow:** out_ready=0, 6 rows with FIFO_DEPTH=4 → level=4, overflow=1 after the 5th row, rows 1–4 drained intact in order once out_ready=1.
- **Full with simultaneous push/pop:** FIFO full, out_ready=1 during an incoming aligned row → row accepted, level stays 4, overflow stays 0.
- **Skew error:** column 2 valid one cycle late → skew_err=1, no row pushed, level=0; err_clear pulse → skew_err=0 the next cycle.
- **Reset mid-flight:** assert reset with 2 rows in the FIFO and 1 row in the deskew chain → all outputs 0 immediately; after release, no out_valid without new input.

Source files
------------

// File: rtl/systolic_drain_pkg.sv
// Shared types for the systolic drain: classification of the aligned valid vector.
package systolic_drain_pkg;

  typedef enum logic [1:0] {
    ALIGN_IDLE,
    ALIGN_ROW,
    ALIGN_SKEW
  } align_e;

  function automatic align_e classify_align(input logic all_valid, input logic any_valid);
    align_e res;
    res = ALIGN_IDLE;
    if (all_valid)      res = ALIGN_ROW;
    else if (any_valid) res = ALIGN_SKEW;
    return res;
  endfunction

endpackage

// File: rtl/systolic_drain_row_fifo.sv
// Synchronous row FIFO with occupancy count; a push while full is taken only alongside a pop.
module drain_row_fifo #(
  parameter int unsigned DW    = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(DEPTH));
  assign level = count_q;
  assign rdata = mem_q[rptr_q];

  // When full, wptr == rptr: the write lands in the slot being popped this cycle.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + LW'(1);
    else if (!wr_en && rd_en) count_d = count_q - LW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (rd_en) rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// Removes the per-column skew from the systolic array output, checks row alignment
// and buffers whole rows for a valid/ready consumer with sticky loss flags.
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned COLS       = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COLS*WIDTH-1:0]         col_data,
  input  logic [COLS-1:0]               col_valid,
  output logic [COLS*WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic                          skew_err,
  input  logic                          err_clear,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  logic [COLS*WIDTH-1:0] aligned_data;
  logic [COLS-1:0]       aligned_valid;
  align_e                align;
  logic                  row_push, pop, fifo_empty, fifo_full;
  logic                  overflow_q, overflow_d, skew_q, skew_d;

  // Column c gets COLS-c stages so every column of a row emerges on the same cycle.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int unsigned STAGES = COLS - c;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned s = 0; s < STAGES; s++) data_q[s] <= '0;
        valid_q <= '0;
      end else begin
        data_q[0]  <= col_data[c*WIDTH +: WIDTH];
        valid_q[0] <= col_valid[c];
        for (int unsigned s = 1; s < STAGES; s++) begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
        end
      end
    end

    assign aligned_data[c*WIDTH +: WIDTH] = data_q[STAGES-1];
    assign aligned_valid[c]               = valid_q[STAGES-1];
  end

  always_comb begin
    align      = classify_align(&aligned_valid, |aligned_valid);
    row_push   = (align == ALIGN_ROW);
    pop        = out_valid & out_ready;
    overflow_d = overflow_q;
    skew_d     = skew_q;
    if (err_clear) begin
      overflow_d = 1'b0;
      skew_d     = 1'b0;
    end
    if (row_push && fifo_full && !pop) overflow_d = 1'b1;
    if (align == ALIGN_SKEW)           skew_d     = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      skew_q     <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      skew_q     <= skew_d;
    end
  end

  drain_row_fifo #(
    .DW    (COLS*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (row_push),
    .pop   (pop),
    .wdata (aligned_data),
    .rdata (out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign out_valid = ~fifo_empty;
  assign overflow  = overflow_q;
  assign skew_err  = skew_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: skewed row stimulus with a scoreboard of expected rows.
module tb_systolic_drain;

  localparam int unsigned W  = 32;
  localparam int unsigned C  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned DW = C * W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [DW-1:0]          col_data;
  logic [C-1:0]           col_valid;
  logic [DW-1:0]          out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overflow;
  logic                   skew_err;
  logic                   err_clear;
  logic [$clog2(D):0]     level;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q [$];
  logic [W-1:0]  hist_base [C];
  logic          hist_v    [C];

  always #5 clk = ~clk;

  systolic_drain #(
    .WIDTH      (W),
    .COLS       (C),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_data  (col_data),
    .col_valid (col_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .skew_err  (skew_err),
    .err_clear (err_clear),
    .level     (level)
  );

  function automatic logic [DW-1:0] row_of(input logic [W-1:0] base);
    logic [DW-1:0] r;
    for (int c = 0; c < C; c++) r[c*W +: W] = base + W'(c);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of skewed stimulus; a started row's column c appears c cycles later.
  task automatic tick(input bit start, input logic [W-1:0] base, input bit keep);
    for (int k = C - 1; k > 0; k--) begin
      hist_v[k]    = hist_v[k-1];
      hist_base[k] = hist_base[k-1];
    end
    hist_v[0]    = start;
    hist_base[0] = base;
    for (int c = 0; c < C; c++) begin
      col_valid[c]     = hist_v[c];
      col_data[c*W +: W] = hist_v[c] ? hist_base[c] + W'(c) : '0;
    end
    if (start && keep) exp_q.push_back(row_of(base));
    if (out_valid && out_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed unexpected row %0h expected none", out_data);
      end
      if (exp_q.size() != 0) chk("sb_row", out_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic raw_tick(input logic [C-1:0] v, input logic [W-1:0] base);
    col_valid = v;
    for (int c = 0; c < C; c++) col_data[c*W +: W] = v[c] ? base + W'(c) : '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nvalid, first, last, maxlvl, flagseen;

    reset     = 1'b1;
    out_ready = 1'b0;
    err_clear = 1'b0;
    col_data  = '0;
    col_valid = '0;
    for (int k = 0; k < C; k++) begin
      hist_v[k]    = 1'b0;
      hist_base[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_level",     DW'(level),     DW'(0));
    chk("rst_overflow",  DW'(overflow),  DW'(0));
    chk("rst_skew_err",  DW'(skew_err),  DW'(0));
    chk("rst_out_data",  out_data,       DW'(0));
    reset = 1'b0;
    tick(1'b0, '0, 1'b0);

    // Single row: out_valid appears COLS edges after the column-0 edge.
    out_ready = 1'b1;
    tick(1'b1, 32'h10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b0);
      chk("single_early_valid", DW'(out_valid), DW'(0));
    end
    tick(1'b0, '0, 1'b0);
    chk("single_valid", DW'(out_valid), DW'(1));
    chk("single_level", DW'(level), DW'(1));
    chk("single_data",  out_data, 128'h00000013_00000012_00000011_00000010);
    tick(1'b0, '0, 1'b0);
    chk("single_drop_valid", DW'(out_valid), DW'(0));
    chk("single_drop_level", DW'(level), DW'(0));

    // Back-to-back stream.
    nvalid = 0; first = -1; last = -1; maxlvl = 0; flagseen = 0;
    for (int i = 0; i < 8 + C + 2; i++) begin
      tick(i < 8, W'(32'h100 * (i + 1)), 1'b1);
      if (out_valid) begin
        nvalid++;
        if (first < 0) first = i;
        last = i;
      end
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (overflow || skew_err) flagseen = 1;
    end
    chk("b2b_count",  DW'(nvalid), DW'(8));
    chk("b2b_span",   DW'(last - first + 1), DW'(8));
    chk("b2b_maxlvl", DW'(maxlvl), DW'(1));
    chk("b2b_flags",  DW'(flagseen), DW'(0));
    chk("b2b_drained", DW'(exp_q.size()), DW'(0));

    // Overflow: six rows into a four-deep FIFO with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, W'(32'h2000 + 32'h100 * i), i < 4);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    chk("ovf_level_full", DW'(level), DW'(4));
    chk("ovf_not_yet",    DW'(overflow), DW'(0));
    tick(1'b0, '0, 1'b0);
    chk("ovf_set",        DW'(overflow), DW'(1));
    chk("ovf_level_hold", DW'(level), DW'(4));
    tick(1'b0, '0, 1'b0);
    chk("ovf_level_6th",  DW'(level), DW'(4));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0);
    chk("ovf_drain_level", DW'(level), DW'(0));
    chk("ovf_drain_sb",    DW'(exp_q.size()), DW'(0));
    chk("ovf_sticky",      DW'(overflow), DW'(1));
    err_clear = 1'b1;
    tick(1'b0, '0, 1'b0);
    err_clear = 1'b0;
    chk("ovf_cleared", DW'(overflow), DW'(0));

    // Full FIFO with a push and pop landing on the same edge.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, W'(32'h3000 + 32'h100 * i), 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0);
    chk("fpp_full", DW'(level), DW'(4));
    tick(1'b1, 32'h3400, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0);
    out_ready = 1'b1;
    tick(1'b0, '0, 1'b0);
    chk("fpp_level",    DW'(level), DW'(4));
    chk("fpp_overflow", DW'(overflow), DW'(0));
    for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0);
    chk("fpp_drain_level", DW'(level), DW'(0));
    chk("fpp_drain_sb",    DW'(exp_q.size()), DW'(0));

    // Skew error: column 2 one cycle late.
    raw_tick(4'b0001, 32'h4000);
    raw_tick(4'b0010, 32'h4000);
    raw_tick(4'b0000, 32'h4000);
    raw_tick(4'b1100, 32'h4000);
    chk("skew_not_early", DW'(skew_err), DW'(0));
    tick(1'b0, '0, 1'b0);
    chk("skew_set", DW'(skew_err), DW'(1));
    for (int i = 0; i < 2; i++) tick(1'b0, '0, 1'b0);
    chk("skew_level",    DW'(level), DW'(0));
    chk("skew_no_valid", DW'(out_valid), DW'(0));
    err_clear = 1'b1;
    tick(1'b0, '0, 1'b0);
    err_clear = 1'b0;
    chk("skew_cleared", DW'(skew_err), DW'(0));

    // Reset with two rows buffered and one still in the deskew chain.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, W'(32'h5000 + 32'h100 * i), 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0);
    chk("mid_level_pre", DW'(level), DW'(2));
    reset = 1'b1;
    #1;
    chk("mid_out_valid", DW'(out_valid), DW'(0));
    chk("mid_level",     DW'(level), DW'(0));
    chk("mid_overflow",  DW'(overflow), DW'(0));
    chk("mid_skew_err",  DW'(skew_err), DW'(0));
    chk("mid_out_data",  out_data, DW'(0));
    exp_q.delete();
    for (int k = 0; k < C; k++) hist_v[k] = 1'b0;
    col_valid = '0;
    col_data  = '0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < C + 3; i++) begin
      tick(1'b0, '0, 1'b0);
      if (out_valid) nvalid++;
    end
    chk("post_rst_quiet", DW'(nvalid), DW'(0));
    chk("post_rst_level", DW'(level), DW'(0));

    tick(1'b1, 32'h6000, 1'b1);
    for (int i = 0; i < C + 1; i++) tick(1'b0, '0, 1'b0);
    chk("post_rst_row_sb", DW'(exp_q.size()), DW'(0));
    chk("post_rst_row_level", DW'(level), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
